// File: rtl/pc_fetch_unit.sv
// Fetch stage sitting directly in front of the instruction memory.
// It owns the PC, presents it to the IM every cycle and captures the returned
// word into an IF/ID register that uses a valid/ready handshake. It also handles
// branch redirects, the HALT encoding and out-of-range redirect faults.
module pc_fetch_unit #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 16,
  parameter int                     IM_BYTES    = 56,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = '1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    updatedPC,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   id_ready,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic                   halted,
  output logic                   fetch_fault,
  output logic [15:0]            fetch_count
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  // End of the IM address space; a fetch address must stay strictly below it.
  localparam logic [PC_WIDTH-1:0] IM_LIMIT = PC_WIDTH'(IM_BYTES);
  // Instructions are halfword aligned, so the PC never carries bit 0.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  state_t                   state_q;
  logic [PC_WIDTH-1:0]      pc_q;
  logic                     if_valid_q;
  logic [INSTR_WIDTH-1:0]   if_instr_q;
  logic [PC_WIDTH-1:0]      if_pc_q;
  logic                     halted_q;
  logic                     fetch_fault_q;
  logic [15:0]              fetch_count_q;

  logic                     slot_free;
  logic                     consume;
  logic [PC_WIDTH-1:0]      target_d;
  logic                     target_ok;
  logic [PC_WIDTH-1:0]      pc_plus2;
  logic [PC_WIDTH-1:0]      pc_seq_d;
  logic [15:0]              fetch_count_d;

  // The IF/ID slot can take a new word when empty or when decode drains it now.
  assign slot_free = !if_valid_q || id_ready;
  assign consume   = if_valid_q && id_ready;

  // Redirect target is forced halfword aligned before the range check.
  assign target_d  = branch_target & ALIGN_MASK;
  assign target_ok = (target_d < IM_LIMIT);

  // Sequential next PC wraps to zero once it walks off the end of the IM.
  assign pc_plus2  = pc_q + PC_WIDTH'(2);
  assign pc_seq_d  = (pc_plus2 == IM_LIMIT) ? '0 : pc_plus2;

  // Capture counter saturates rather than rolling over.
  assign fetch_count_d = (fetch_count_q == 16'hFFFF) ? fetch_count_q
                                                     : fetch_count_q + 16'd1;

  // Fetch FSM: redirect beats capture, capture beats hold; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC_ALIGNED;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      halted_q      <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_count_q <= '0;
    end else if (branch_taken) begin
      // A redirect always flushes the slot, even if decode is taking it.
      if_valid_q <= 1'b0;
      if (target_ok) begin
        pc_q     <= target_d;
        state_q  <= FETCH;
        halted_q <= 1'b0;
      end else begin
        fetch_fault_q <= 1'b1;
        state_q       <= FAULT;
        halted_q      <= 1'b1;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (slot_free) begin
            if_instr_q    <= instruction;
            if_pc_q       <= pc_q;
            if_valid_q    <= 1'b1;
            fetch_count_q <= fetch_count_d;
            if (instruction == HALT_INSTR) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_seq_d;
            end
          end
        end
        HALTED, FAULT: begin
          // Fetch is stopped; only let the last captured word drain.
          if (consume) begin
            if_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign updatedPC   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign halted      = halted_q;
  assign fetch_fault = fetch_fault_q;
  assign fetch_count = fetch_count_q;

endmodule
